view_scan_ctrl: RTL and testbench

- Canvas scan sequencer directly upstream of the view-ray generator.
- On a start pulse it latches the camera normal and view distance, then drives canvas coordinates in raster order.
- After each coordinate change it waits a fixed settle time covering the generator's clocked magnitude path, captures the returned ray, and offers it downstream on a valid/ready handshake tagged with its pixel location.

---
 rtl/view_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_view_scan_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/view_scan_ctrl.sv
// view_scan_ctrl: canvas scan sequencer that feeds the view-ray generator.
//
// A start pulse latches the camera normal/distance and walks view_loc over the
// canvas in raster order (x fastest). After every view_loc change the block
// waits SETTLE cycles for the generator's registered magnitude path, captures
// view_ray_in, and offers it downstream with its pixel location on a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start, abort  frame start request (IDLE only) and synchronous frame abort
//   cam_normal    camera normal {x[10:0], y[10:0], z[8:0]}, signed fields
//   cam_dist      camera view distance, unsigned
//   view_normal   frame-latched normal, to the generator
//   view_dist     frame-latched distance, to the generator
//   view_loc      current pixel {x[6:0], y[5:0]}, to the generator
//   view_ray_in   ray vector returned by the generator
//   ray_valid     ray_data/ray_loc valid
//   ray_ready     downstream accepts
//   ray_data      captured ray vector
//   ray_loc       pixel location of ray_data
//   busy          frame in progress
//   frame_done    one-cycle pulse after the last pixel is accepted
module view_scan_ctrl #(
    parameter int unsigned COLS   = 128,
    parameter int unsigned ROWS   = 64,
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [30:0] cam_normal,
    input  logic [7:0]  cam_dist,
    output logic [30:0] view_normal,
    output logic [7:0]  view_dist,
    output logic [12:0] view_loc,
    input  logic [30:0] view_ray_in,
    output logic        ray_valid,
    input  logic        ray_ready,
    output logic [30:0] ray_data,
    output logic [12:0] ray_loc,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [6:0] XLast   = 7'(COLS - 1);
    localparam logic [5:0] YLast   = 6'(ROWS - 1);
    localparam logic [3:0] CntInit = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StPresent
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [30:0] normal_q, normal_d;
    logic [7:0]  dist_q, dist_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic [30:0] data_q, data_d;
    logic [12:0] loc_q, loc_d;
    logic        done_q, done_d;

    logic        last_pix;
    logic        handshake;

    assign last_pix  = (x_q == XLast) && (y_q == YLast);
    assign handshake = valid_q && ray_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            normal_q <= '0;
            dist_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            loc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            normal_q <= normal_d;
            dist_q   <= dist_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            loc_q    <= loc_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        normal_d = normal_q;
        dist_d   = dist_q;
        x_d      = x_q;
        y_d      = y_q;
        valid_d  = valid_q;
        data_d   = data_q;
        loc_d    = loc_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort outranks start even though abort is otherwise a no-op here
                if (start && !abort) begin
                    normal_d = cam_normal;
                    dist_d   = cam_dist;
                    x_d      = '0;
                    y_d      = '0;
                    cnt_d    = CntInit;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = view_ray_in;
                    loc_d   = {x_q, y_q};
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (handshake) begin
                    valid_d = 1'b0;
                    if (last_pix) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        if (x_q == XLast) begin
                            x_d = '0;
                            y_d = y_q + 6'd1;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                        cnt_d   = CntInit;
                        state_d = StSettle;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    assign view_normal = normal_q;
    assign view_dist   = dist_q;
    assign view_loc    = {x_q, y_q};
    assign ray_valid   = valid_q;
    assign ray_data    = data_q;
    assign ray_loc     = loc_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;

endmodule

// File: tb/tb_view_scan_ctrl.sv
// Bench for view_scan_ctrl on a 4x2 canvas with SETTLE=4. The reference is a
// pixel-index/cycle-count model: pixel k sits at (k % COLS, k / COLS), its ray
// is whatever the generator drove at edge (settle start + SETTLE), and a
// handshake happens on any edge where the model has valid high and ready high.
module tb_view_scan_ctrl;

    localparam int unsigned COLS   = 4;
    localparam int unsigned ROWS   = 2;
    localparam int unsigned SETTLE = 4;
    localparam int          NPIX   = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [30:0] cam_normal = '0;
    logic [7:0]  cam_dist = '0;
    logic [30:0] view_normal;
    logic [7:0]  view_dist;
    logic [12:0] view_loc;
    logic [30:0] view_ray_in = '0;
    logic        ray_valid;
    logic        ray_ready = 1'b0;
    logic [30:0] ray_data;
    logic [12:0] ray_loc;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Generator stand-in: a fresh value after every edge, logged by the edge
    // at which it is sampled.
    logic [30:0] hist [int];
    logic        force_en = 1'b0;
    logic [30:0] force_val = '0;
    logic [30:0] ray_v;

    view_scan_ctrl #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .SETTLE (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cam_normal  (cam_normal),
        .cam_dist    (cam_dist),
        .view_normal (view_normal),
        .view_dist   (view_dist),
        .view_loc    (view_loc),
        .view_ray_in (view_ray_in),
        .ray_valid   (ray_valid),
        .ray_ready   (ray_ready),
        .ray_data    (ray_data),
        .ray_loc     (ray_loc),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (force_en) ray_v = force_val;
        else ray_v = 31'($urandom);
        view_ray_in = ray_v;
        hist[cyc + 1] = ray_v;
    end

    function automatic logic [12:0] pix_loc(input int k);
        return {7'(k % COLS), 6'(k / COLS)};
    endfunction

    // One full frame checked every cycle against the model. pct is the ready
    // probability; pixel stall_pix sees ready low for its first stall_len
    // valid cycles; noise scrambles camera inputs and pulses start mid-frame.
    task automatic run_frame(input int pct, input int stall_pix, input int stall_len,
                             input bit noise);
        logic [30:0] exp_n;
        logic [7:0]  exp_d;
        int k, s, stall_cnt, budget, kl;
        bit mv, rdy, done;
        @(negedge clk);
        cam_normal = 31'($urandom);
        cam_dist   = 8'($urandom);
        exp_n = cam_normal;
        exp_d = cam_dist;
        abort = 1'b0;
        ray_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc; k = 0; mv = 0; done = 0; stall_cnt = 0; budget = 0;
        vectors++;
        if ({busy, ray_valid, frame_done, view_loc} !== {1'b1, 1'b0, 1'b0, 13'd0}) begin
            miscompares++;
            $display("FAIL frame_start: busy/valid/done/loc=%b/%b/%b/%h want 1/0/0/0000",
                     busy, ray_valid, frame_done, view_loc);
        end
        while (!done && budget < 3000) begin
            @(negedge clk);
            if (noise) begin
                cam_normal = 31'($urandom);
                cam_dist   = 8'($urandom);
                start      = ($urandom_range(0, 3) == 0);
            end
            if (mv && k == stall_pix && stall_cnt < stall_len) begin
                rdy = 0;
                stall_cnt++;
            end else begin
                rdy = ($urandom_range(0, 99) < pct);
            end
            ray_ready = rdy;
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
            if (mv && rdy) begin
                k++;
                mv = 0;
                s = cyc;
                if (k == NPIX) done = 1;
            end else if (!mv && cyc == s + int'(SETTLE)) begin
                mv = 1;
            end
            kl = (k == NPIX) ? NPIX - 1 : k;
            vectors++;
            if ({ray_valid, busy, frame_done} !== {mv, !done, done}) begin
                miscompares++;
                $display("FAIL ctrl k=%0d cyc=%0d: valid/busy/done=%b/%b/%b want %b/%b/%b",
                         k, cyc, ray_valid, busy, frame_done, mv, !done, done);
            end
            vectors++;
            if ({view_loc, view_normal, view_dist} !== {pix_loc(kl), exp_n, exp_d}) begin
                miscompares++;
                $display("FAIL view k=%0d: loc/normal/dist=%h/%h/%h want %h/%h/%h",
                         k, view_loc, view_normal, view_dist, pix_loc(kl), exp_n, exp_d);
            end
            if (mv) begin
                vectors++;
                if ({ray_loc, ray_data} !== {pix_loc(k), hist[s + int'(SETTLE)]}) begin
                    miscompares++;
                    $display("FAIL ray k=%0d: loc/data=%h/%h want %h/%h", k, ray_loc,
                             ray_data, pix_loc(k), hist[s + int'(SETTLE)]);
                end
            end
        end
        start = 1'b0;
        ray_ready = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL frame_timeout: %0d pixels accepted, want %0d", k, NPIX);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({view_normal, view_dist, view_loc, ray_valid, ray_data, ray_loc, busy,
             frame_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b valid=%b loc=%h data=%h want all 0",
                     busy, ray_valid, view_loc, ray_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        run_frame(100, -1, 0, 1'b0);
        @(posedge clk); #1;
        vectors++;
        if ({frame_done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL done_pulse_len: done/busy=%b/%b want 0/0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure();
        run_frame(100, 1, 20, 1'b0);
    endtask

    task automatic test_random_ready_noise();
        for (int i = 0; i < 3; i++) run_frame(55, -1, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame(100, -1, 0, 1'b0);
        run_frame(80, 3, 5, 1'b0);
    endtask

    task automatic test_capture();
        int e0;
        @(negedge clk);
        ray_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
        while (cyc < e0 + int'(SETTLE) - 1) begin
            @(posedge clk); #1;
        end
        force_en = 1'b1;
        force_val = 31'h1234567;
        @(posedge clk); #1;
        force_val = '0;
        vectors++;
        if ({ray_valid, ray_data} !== {1'b1, 31'h1234567}) begin
            miscompares++;
            $display("FAIL capture: valid/data=%b/%h want 1/1234567", ray_valid, ray_data);
        end
        @(posedge clk); #1;
        vectors++;
        if ({ray_valid, ray_data} !== {1'b1, 31'h1234567}) begin
            miscompares++;
            $display("FAIL capture_hold: valid/data=%b/%h want 1/1234567",
                     ray_valid, ray_data);
        end
        force_en = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        vectors++;
        if ({busy, ray_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL capture_abort: busy/valid=%b/%b want 0/0", busy, ray_valid);
        end
    endtask

    task automatic test_abort();
        logic [30:0] exp_n;
        int budget;
        @(negedge clk);
        cam_normal = 31'($urandom);
        cam_dist = 8'($urandom);
        exp_n = cam_normal;
        ray_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (!ray_valid && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        vectors++;
        if (ray_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: valid=%b want 1", ray_valid);
        end
        @(negedge clk);
        ray_ready = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        ray_ready = 1'b0;
        vectors++;
        if ({busy, ray_valid, frame_done, view_loc, view_normal} !==
            {3'b000, 13'd0, exp_n}) begin
            miscompares++;
            $display("FAIL abort_present: busy/valid/done/loc/normal=%b/%b/%b/%h/%h want 0/0/0/0000/%h",
                     busy, ray_valid, frame_done, view_loc, view_normal, exp_n);
        end
        @(posedge clk); #1;
        vectors++;
        if ({busy, frame_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_no_done: busy/done=%b/%b want 0/0", busy, frame_done);
        end
        // abort beats start in IDLE
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_over_start: busy=%b want 0", busy);
        end
        run_frame(100, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        ray_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({view_normal, view_dist, view_loc, ray_valid, ray_data, ray_loc, busy,
             frame_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: busy=%b valid=%b normal=%h want all 0",
                     busy, ray_valid, view_normal);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, frame_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_done: busy/done=%b/%b want 0/0", busy, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ray_ready = 1'b0;
        run_frame(100, -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_random_ready_noise();
        test_back_to_back();
        test_capture();
        test_abort();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
